// File: rtl/bus_pkg.sv
// Shared definitions for the bus cycle controller: state codes, MIO encoding
// and default bus widths.
package bus_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    // Bus cycle phases, legacy-compatible 3-bit codes.
    typedef logic [2:0] state_t;
    localparam state_t IDLE = 3'd0;
    localparam state_t T1   = 3'd1;
    localparam state_t T2   = 3'd2;
    localparam state_t T3   = 3'd3;
    localparam state_t TW   = 3'd4;
    localparam state_t T4   = 3'd5;

    // MIO as the address decoder expects it.
    localparam logic MIO_MEM = 1'b1;
    localparam logic MIO_IO  = 1'b0;

    // Phases during which the RD/WR strobe is held asserted.
    function automatic logic strobe_state(input state_t s);
        return (s == T2) || (s == T3) || (s == TW);
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter: cleared in T2, counts TW cycles, saturates at 255.
// ge_min says the mandatory wait states are served, timeout says the slave
// has had its full allowance.
module bus_wait_timer #(
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic ge_min,
    output logic timeout
);

    logic [7:0] count;

    // Count wait states; load wins over increment, never wraps past 255.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'd0;
        end else if (inc && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign ge_min  = (int'(count) >= MIN_WAIT);
    assign timeout = (int'(count) >= TIMEOUT);

endmodule

// File: rtl/bus_cycle_controller.sv
// 8086-style T1..T4 bus master with optional wait states and timeout.
// All bus-facing outputs are registered so strobes are glitch-free; they are
// updated from the next-state value so each phase shows its levels for the
// whole cycle it occupies.
module bus_cycle_controller
    import bus_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MIN_WAIT = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              req_write,
    input  logic              req_io,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic              MIO,
    output logic              ALE,
    output logic              rd_n,
    output logic              wr_n,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ready
);

    state_t            state;
    state_t            state_nxt;
    logic              abort_nxt;
    logic              cyc_write;
    logic [DATA_W-1:0] cyc_wdata;
    logic              wait_load;
    logic              wait_inc;
    logic              wait_ge_min;
    logic              wait_timeout;

    assign wait_load = (state == T2);
    assign wait_inc  = ((state == T3) || (state == TW)) && (state_nxt == TW);

    bus_wait_timer #(
        .MIN_WAIT (MIN_WAIT),
        .TIMEOUT  (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (wait_load),
        .inc     (wait_inc),
        .ge_min  (wait_ge_min),
        .timeout (wait_timeout)
    );

    // Next phase; a served ready beats the timeout in the same TW cycle.
    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        case (state)
            IDLE: if (req) state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3: begin
                if (!wait_ge_min || !ready) state_nxt = TW;
                else                        state_nxt = T4;
            end
            TW: begin
                if (wait_ge_min && ready) begin
                    state_nxt = T4;
                end else if (wait_timeout) begin
                    state_nxt = T4;
                    abort_nxt = 1'b1;
                end
            end
            T4:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Phase register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request capture; address and MIO then hold until the next request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address   <= '0;
            MIO       <= MIO_MEM;
            cyc_write <= 1'b0;
            cyc_wdata <= '0;
        end else if ((state == IDLE) && req) begin
            address   <= req_addr;
            MIO       <= req_io ? MIO_IO : MIO_MEM;
            cyc_write <= req_write;
            cyc_wdata <= req_wdata;
        end
    end

    // Bus strobes and handshake outputs, registered from the upcoming phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ALE      <= 1'b0;
            busy     <= 1'b0;
            rd_n     <= 1'b1;
            wr_n     <= 1'b1;
            data_oe  <= 1'b0;
            data_out <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            ALE     <= (state_nxt == T1);
            busy    <= (state_nxt != IDLE);
            rd_n    <= !(strobe_state(state_nxt) && !cyc_write);
            wr_n    <= !(strobe_state(state_nxt) && cyc_write);
            data_oe <= strobe_state(state_nxt) && cyc_write;
            done    <= (state_nxt == T4) && !abort_nxt;
            error   <= (state_nxt == T4) && abort_nxt;
            if ((state == T1) && cyc_write) data_out <= cyc_wdata;
        end
    end

    // Read data is taken on the edge that releases rd_n, only on success.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if ((state_nxt == T4) && !abort_nxt && !cyc_write) begin
            rdata <= data_in;
        end
    end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: three instances with different wait
// configurations, a transfer-level expectation model, a per-cycle compare
// process and a few literal expectations.
module tb_bus_cycle_controller;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int NI = 3;

    function automatic int cfg_min(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_to(input int i);
        case (i)
            0:       return 15;
            1:       return 15;
            default: return 4;
        endcase
    endfunction

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic          req_s [NI];
    logic          wr_s [NI];
    logic          io_s [NI];
    logic          ready_s [NI];
    logic [AW-1:0] addr_s [NI];
    logic [DW-1:0] wdata_s [NI];
    logic [DW-1:0] din_s [NI];
    logic          busy_s [NI];
    logic          done_s [NI];
    logic          error_s [NI];
    logic [DW-1:0] rdata_s [NI];
    logic [AW-1:0] address_s [NI];
    logic          mio_s [NI];
    logic          ale_s [NI];
    logic          rd_n_s [NI];
    logic          wr_n_s [NI];
    logic [DW-1:0] dout_s [NI];
    logic          oe_s [NI];

    logic          exp_busy [NI];
    logic          exp_done [NI];
    logic          exp_err [NI];
    logic [DW-1:0] exp_rdata [NI];
    logic [AW-1:0] exp_addr [NI];
    logic          exp_mio [NI];
    logic          exp_ale [NI];
    logic          exp_rd_n [NI];
    logic          exp_wr_n [NI];
    logic [DW-1:0] exp_dout [NI];
    logic          exp_oe [NI];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat_cnt [NI]   = '{default: 0};
    int last_lat [NI]  = '{default: 0};
    int last_kind [NI] = '{default: 0};
    int prev_end [NI]  = '{default: 0};
    int last_end [NI]  = '{default: 0};

    for (genvar g = 0; g < NI; g++) begin : g_dut
        bus_cycle_controller #(
            .ADDR_W   (AW),
            .DATA_W   (DW),
            .MIN_WAIT (cfg_min(g)),
            .TIMEOUT  (cfg_to(g))
        ) dut (
            .clock     (clock),
            .reset     (reset),
            .req       (req_s[g]),
            .req_write (wr_s[g]),
            .req_io    (io_s[g]),
            .req_addr  (addr_s[g]),
            .req_wdata (wdata_s[g]),
            .busy      (busy_s[g]),
            .done      (done_s[g]),
            .error     (error_s[g]),
            .rdata     (rdata_s[g]),
            .address   (address_s[g]),
            .MIO       (mio_s[g]),
            .ALE       (ale_s[g]),
            .rd_n      (rd_n_s[g]),
            .wr_n      (wr_n_s[g]),
            .data_out  (dout_s[g]),
            .data_oe   (oe_s[g]),
            .data_in   (din_s[g]),
            .ready     (ready_s[g])
        );
    end

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, want, $time);
        end
    endtask

    task automatic set_idle_exp(input int i);
        exp_busy[i] = 1'b0;
        exp_ale[i]  = 1'b0;
        exp_rd_n[i] = 1'b1;
        exp_wr_n[i] = 1'b1;
        exp_oe[i]   = 1'b0;
        exp_done[i] = 1'b0;
        exp_err[i]  = 1'b0;
    endtask

    task automatic set_reset_exp();
        for (int i = 0; i < NI; i++) begin
            set_idle_exp(i);
            exp_addr[i]  = '0;
            exp_mio[i]   = 1'b1;
            exp_rdata[i] = '0;
            exp_dout[i]  = '0;
        end
    endtask

    // Compare every instance against the model on every falling edge.
    always @(negedge clock) begin
        for (int i = 0; i < NI; i++) begin
            chk("busy",    i, 32'(busy_s[i]),    32'(exp_busy[i]));
            chk("done",    i, 32'(done_s[i]),    32'(exp_done[i]));
            chk("error",   i, 32'(error_s[i]),   32'(exp_err[i]));
            chk("rdata",   i, 32'(rdata_s[i]),   32'(exp_rdata[i]));
            chk("address", i, 32'(address_s[i]), 32'(exp_addr[i]));
            chk("MIO",     i, 32'(mio_s[i]),     32'(exp_mio[i]));
            chk("ALE",     i, 32'(ale_s[i]),     32'(exp_ale[i]));
            chk("rd_n",    i, 32'(rd_n_s[i]),    32'(exp_rd_n[i]));
            chk("wr_n",    i, 32'(wr_n_s[i]),    32'(exp_wr_n[i]));
            chk("data_oe", i, 32'(oe_s[i]),      32'(exp_oe[i]));
            if (exp_oe[i] || reset)
                chk("data_out", i, 32'(dout_s[i]), 32'(exp_dout[i]));
        end
    end

    // Transfer monitor: busy length and end cycle of each completed transfer.
    always @(negedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                lat_cnt[i] = 0;
            end else begin
                if (busy_s[i]) lat_cnt[i]++;
                if (done_s[i] || error_s[i]) begin
                    last_lat[i]  = lat_cnt[i];
                    lat_cnt[i]   = 0;
                    last_kind[i] = done_s[i] ? 1 : 2;
                    prev_end[i]  = last_end[i];
                    last_end[i]  = cyc;
                end
            end
        end
    end

    task automatic idle_cycles(input int i, input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clock); #1;
            set_idle_exp(i);
            req_s[i]   = 1'b0;
            wr_s[i]    = 1'($urandom);
            io_s[i]    = 1'($urandom);
            addr_s[i]  = AW'($urandom);
            wdata_s[i] = DW'($urandom);
            ready_s[i] = 1'($urandom);
            din_s[i]   = DW'($urandom);
        end
    endtask

    // One transfer. rdy[k] is ready in the k-th cycle after T2 (T3 is k=0).
    // The model: wait states n = first k >= MIN_WAIT with ready high; if
    // that exceeds TIMEOUT the cycle aborts after TIMEOUT wait states.
    // abort_at > 0 asserts reset part-way into that transfer cycle.
    task automatic run_xfer(input int i, input logic wr, input logic io, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [31:0] rdy, input int abort_at,
                            input int dfix);
        int            mn;
        int            to;
        int            n;
        int            last;
        logic          ok;
        logic          strobe;
        logic [DW-1:0] din_keep;
        mn = cfg_min(i);
        to = cfg_to(i);
        ok = 1'b0;
        n  = to;
        for (int k = 0; k <= to; k++) begin
            if (!ok && (k >= mn) && rdy[k]) begin
                ok = 1'b1;
                n  = k;
            end
        end
        last     = 4 + n;
        din_keep = '0;

        @(posedge clock); #1;
        set_idle_exp(i);
        req_s[i]   = 1'b1;
        wr_s[i]    = wr;
        io_s[i]    = io;
        addr_s[i]  = a;
        wdata_s[i] = wd;
        ready_s[i] = 1'($urandom);
        din_s[i]   = DW'($urandom);

        for (int c = 1; c <= last; c++) begin
            @(posedge clock); #1;
            strobe       = (c >= 2) && (c <= 3 + n);
            exp_busy[i]  = 1'b1;
            exp_ale[i]   = (c == 1);
            exp_done[i]  = 1'b0;
            exp_err[i]   = 1'b0;
            if (c == 1) begin
                exp_addr[i] = a;
                exp_mio[i]  = ~io;
            end
            exp_rd_n[i] = !(strobe && !wr);
            exp_wr_n[i] = !(strobe && wr);
            exp_oe[i]   = strobe && wr;
            if (strobe && wr) exp_dout[i] = wd;
            if (c == last) begin
                exp_done[i] = ok;
                exp_err[i]  = !ok;
                if (ok && !wr) exp_rdata[i] = din_keep;
            end
            req_s[i]   = 1'b1;
            wr_s[i]    = 1'($urandom);
            io_s[i]    = 1'($urandom);
            addr_s[i]  = AW'($urandom);
            wdata_s[i] = DW'($urandom);
            ready_s[i] = (c >= 3) ? rdy[c-3] : 1'($urandom);
            din_s[i]   = (dfix >= 0) ? DW'(dfix) : DW'($urandom);
            if (c == 3 + n) din_keep = din_s[i];
            if (c == abort_at) begin
                req_s[i] = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("rst_async_rd_n", i, 32'(rd_n_s[i]), 32'd1);
                chk("rst_async_busy", i, 32'(busy_s[i]), 32'd0);
                chk("rst_async_oe",   i, 32'(oe_s[i]),   32'd0);
                set_reset_exp();
                return;
            end
        end
    endtask

    initial begin
        int            i;
        int            prev_i;
        int            mode;
        logic [31:0]   rdy;
        for (int k = 0; k < NI; k++) begin
            req_s[k]   = 1'b0;
            wr_s[k]    = 1'b0;
            io_s[k]    = 1'b0;
            ready_s[k] = 1'b1;
            addr_s[k]  = '0;
            wdata_s[k] = '0;
            din_s[k]   = '0;
        end
        set_reset_exp();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        chk("lit_reset_mio", 0, 32'(mio_s[0]), 32'd1);

        // Memory read, zero wait.
        run_xfer(0, 1'b0, 1'b0, 16'h0400, 8'h00, 32'hFFFF_FFFF, 0, 8'hA5);
        idle_cycles(0, 1);
        chk("lit_rd_rdata", 0, 32'(rdata_s[0]),   32'h0000_00A5);
        chk("lit_rd_lat",   0, last_lat[0],        32'd4);
        chk("lit_rd_kind",  0, last_kind[0],       32'd1);
        chk("lit_rd_addr",  0, 32'(address_s[0]), 32'h0000_0400);

        // I/O write, zero wait.
        run_xfer(0, 1'b1, 1'b1, 16'h0001, 8'h3C, 32'hFFFF_FFFF, 0, -1);
        idle_cycles(0, 1);
        chk("lit_wr_lat",   0, last_lat[0],        32'd4);
        chk("lit_wr_mio",   0, 32'(mio_s[0]),     32'd0);
        chk("lit_wr_rdata", 0, 32'(rdata_s[0]),   32'h0000_00A5);

        // Ready low for three cycles after T2.
        run_xfer(0, 1'b0, 1'b0, 16'h8000, 8'h00, 32'h0000_0008, 0, 8'h5A);
        idle_cycles(0, 1);
        chk("lit_wait_lat",   0, last_lat[0],      32'd7);
        chk("lit_wait_rdata", 0, 32'(rdata_s[0]), 32'h0000_005A);

        // Ready stuck low: timeout after 15 wait states.
        run_xfer(0, 1'b0, 1'b0, 16'h1000, 8'h00, 32'h0, 0, 8'hEE);
        idle_cycles(0, 1);
        chk("lit_to_lat",   0, last_lat[0],      32'd19);
        chk("lit_to_kind",  0, last_kind[0],     32'd2);
        chk("lit_to_rdata", 0, 32'(rdata_s[0]), 32'h0000_005A);

        // MIN_WAIT = 2 with ready always high.
        run_xfer(1, 1'b0, 1'b0, 16'h0400, 8'h00, 32'hFFFF_FFFF, 0, 8'hC3);
        idle_cycles(1, 1);
        chk("lit_min_lat",   1, last_lat[1],      32'd6);
        chk("lit_min_rdata", 1, 32'(rdata_s[1]), 32'h0000_00C3);

        // MIN_WAIT > TIMEOUT always ends in error.
        run_xfer(2, 1'b0, 1'b0, 16'h0400, 8'h00, 32'hFFFF_FFFF, 0, 8'h99);
        idle_cycles(2, 1);
        chk("lit_cfg_lat",   2, last_lat[2],      32'd8);
        chk("lit_cfg_kind",  2, last_kind[2],     32'd2);
        chk("lit_cfg_rdata", 2, 32'(rdata_s[2]), 32'h0);

        // Back-to-back with req held high.
        for (int k = 0; k < 3; k++)
            run_xfer(0, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), 32'hFFFF_FFFF, 0, -1);
        idle_cycles(0, 1);
        chk("lit_b2b_period0", 0, last_end[0] - prev_end[0], 32'd5);
        for (int k = 0; k < 2; k++)
            run_xfer(1, 1'b0, 1'b0, AW'($urandom), 8'h00, 32'hFFFF_FFFF, 0, -1);
        idle_cycles(1, 1);
        chk("lit_b2b_period1", 1, last_end[1] - prev_end[1], 32'd7);

        // Reset during the second wait state, then a normal read.
        run_xfer(0, 1'b0, 1'b0, 16'h1234, 8'h00, 32'h0, 5, -1);
        @(posedge clock);
        #2 reset = 1'b0;
        run_xfer(0, 1'b0, 1'b0, 16'h2222, 8'h00, 32'hFFFF_FFFF, 0, 8'h77);
        idle_cycles(0, 1);
        chk("lit_post_rst_rdata", 0, 32'(rdata_s[0]), 32'h0000_0077);
        chk("lit_post_rst_lat",   0, last_lat[0],      32'd4);

        // Randomised transfers across all three configurations.
        prev_i = 0;
        repeat (60) begin
            i    = $urandom_range(0, NI - 1);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rdy = 32'hFFFF_FFFF;
                1:       rdy = $urandom;
                2:       rdy = 32'h0;
                default: rdy = 32'd1 << $urandom_range(0, 10);
            endcase
            if (i != prev_i) idle_cycles(prev_i, 1);
            run_xfer(i, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), rdy, 0, -1);
            if ($urandom_range(0, 1) == 1) idle_cycles(i, $urandom_range(1, 2));
            prev_i = i;
        end
        idle_cycles(prev_i, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/bus_cycle_controller.md
Name: bus_cycle_controller

Overview:
Upstream master stage for the address decoder. It accepts single-transfer requests from the processor-side core and runs an 8086-style T1–T4 bus cycle with optional wait states. It drives the latched address, MIO and ALE that the decoder consumes, plus the active-low RD/WR strobes, and it returns read data or a timeout error to the requester.

Parameters:
ADDR_W, 16, width of request and latched bus address
DATA_W, 8, data bus width
MIN_WAIT, 0, number of wait states always inserted, independent of the ready input
TIMEOUT, 15, maximum wait-state cycles before the cycle is aborted with an error (valid range 1..255)

Ports:
clock  in  1  system clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
req  in  1  start a transfer; sampled only in IDLE
req_write  in  1  1 = write, 0 = read
req_io  in  1  1 = I/O space, 0 = memory space
req_addr  in  ADDR_W  target address
req_wdata  in  DATA_W  write data
busy  out  1  high from T1 through T4
done  out  1  one-cycle pulse at T4 on success
error  out  1  one-cycle pulse at T4 on timeout
rdata  out  DATA_W  captured read data, held until the next read completes
address  out  ADDR_W  latched bus address for the decoder
MIO  out  1  1 = memory, 0 = I/O (decoder encoding)
ALE  out  1  address latch enable
rd_n  out  1  active-low read strobe
wr_n  out  1  active-low write strobe
data_out  out  DATA_W  write data driven onto the bus
data_oe  out  1  data_out drive enable
data_in  in  DATA_W  bus read data
ready  in  1  slave ready; low inserts wait states

Behaviour:
- Reset (asynchronous, active-high; reset is asynchronous and active-high, single clock):
  - state = IDLE; address = 0; MIO = 1; ALE = 0; rd_n = wr_n = 1; data_oe = 0; data_out = 0; rdata = 0; busy = done = error = 0.
  - Reset asserted mid-cycle aborts immediately. Strobes deassert asynchronously, and no done or error pulse is produced.
- States: IDLE, T1, T2, T3, TW, T4.
- IDLE:
  - If req = 1, capture req_addr, req_io, req_write and req_wdata into registers and go to T1. Otherwise stay in IDLE.
  - address and MIO hold their last values in IDLE; they do not return to 0.
- T1 (1 cycle):
  - ALE = 1; address = captured address; MIO = ~req_io; busy = 1.
  - The decoder registers cs on the edge that leaves T1, so cs is valid from T2 onward.
- T2 (1 cycle):
  - ALE = 0.
  - Read: rd_n = 0.
  - Write: wr_n = 0, data_oe = 1, data_out = captured wdata.
  - Load the wait counter with 0.
- T3:
  - Strobes stay asserted.
  - If the wait counter < MIN_WAIT, or ready = 0, go to TW. Otherwise go to T4.
- TW:
  - Strobes stay asserted; the wait counter increments each cycle.
  - Leave for T4 when the counter ≥ MIN_WAIT and ready = 1.
  - When the counter reaches TIMEOUT with ready still low, set the abort flag and go to T4.
  - The counter saturates and never wraps.
- T4 (1 cycle):
  - rd_n = wr_n = 1; data_oe = 0.
  - On a read without abort, rdata is captured from data_in on entry to T4, i.e. on the same edge the strobe deasserts.
  - Pulse done (no abort) or error (abort). rdata is unchanged on a write or on an abort.
  - Next state is IDLE. busy drops on the edge leaving T4.
- Minimum latency, req sampled to done: 4 cycles (T1, T2, T3, T4).
- req asserted while busy is ignored; there is no queueing. req asserted in the cycle done pulses is also ignored, because the state is T4, not IDLE.
- rd_n and wr_n are never low simultaneously. Strobes are registered and glitch-free.
- With MIN_WAIT > TIMEOUT the cycle always ends in error. This is a legal configuration and the bench flags it.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, T1, T2, T3, TW, T4}
  - MIO_MEM = 1, MIO_IO = 0
  - default ADDR_W and DATA_W
- One natural sub-module, bus_wait_timer: an 8-bit saturating counter with load, increment, ge_min and timeout outputs, parameterised by MIN_WAIT and TIMEOUT.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Memory read: req_io = 0, addr = 0x0400, ready = 1, data_in = 0xA5 → ALE high in T1 only; MIO = 1; rd_n low for T2–T3; done in cycle 4; rdata = 0xA5; the decoder then selects EEPROM (cs = 10111).
- I/O write: req_io = 1, write, addr = 0x0001, wdata = 0x3C → MIO = 0; wr_n low T2–T3; data_oe = 1 with data_out = 0x3C; done in cycle 4; decoder cs = 11101.
- Wait states: ready held low for 3 cycles after T2 → 3 TW cycles; done in cycle 7; strobe continuously low until T4.
- Timeout: ready stuck at 0, TIMEOUT = 15 → error pulse after 15 TW cycles; done = 0; rdata unchanged.
- Reset mid-cycle: assert reset during TW → rd_n = 1 immediately without waiting for a clock edge; no done or error; next req runs normally.
- Back-to-back: req held high continuously → transfers start every 5 cycles; the req present during T1–T4 is ignored; MIN_WAIT = 2 adds exactly 2 TW cycles per transfer.
